// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture packer: FSM states, status bit placement
// and the word-width legality check.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_e;

  // Status bits counted down from the word MSB.
  localparam int unsigned OR_BIT_FROM_MSB   = 0;
  localparam int unsigned TRIG_BIT_FROM_MSB = 1;
  localparam int unsigned STATUS_BITS       = 2;

  function automatic bit word_width_ok(input int unsigned word_width,
                                       input int unsigned spw,
                                       input int unsigned adc_width);
    return (spw >= 1) && (spw <= 4) && (word_width >= spw * adc_width + STATUS_BITS);
  endfunction

endpackage

// File: rtl/adc_capture_packer_if.sv
// Single-clock FIFO write port driven by the capture packer.
interface adc_capture_packer_if #(
  parameter int unsigned WORD_WIDTH = 32
);
  logic                  fifo_wr_en_o;
  logic [WORD_WIDTH-1:0] fifo_din_o;
  logic                  fifo_full_i;

  modport master (output fifo_wr_en_o, output fifo_din_o, input fifo_full_i);
  modport slave  (input fifo_wr_en_o, input fifo_din_o, output fifo_full_i);
endinterface

// File: rtl/adc_lane_packer.sv
// Accumulates accepted samples into lanes with sticky overrange and last-trigger status;
// presents the assembled word combinationally and clears itself once a word is taken.
module adc_lane_packer
  import adc_capture_pkg::*;
#(
  parameter  int unsigned ADC_WIDTH  = 10,
  parameter  int unsigned SPW        = 3,
  parameter  int unsigned WORD_WIDTH = 32,
  localparam int unsigned LANE_W     = (SPW > 1) ? $clog2(SPW) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  acc_i,
  input  logic                  flush_i,
  input  logic [ADC_WIDTH-1:0]  sample_i,
  input  logic                  or_i,
  input  logic                  trig_i,
  output logic [LANE_W-1:0]     lane_o,
  output logic                  last_lane_c,
  output logic [WORD_WIDTH-1:0] word_c
);

  localparam int unsigned DATA_W = SPW * ADC_WIDTH;

  logic [DATA_W-1:0] lanes_q, lanes_d, lanes_ins;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              or_q, or_d, trig_q, trig_d;

  always_comb begin
    lanes_ins = lanes_q;
    lanes_ins[lane_q * ADC_WIDTH +: ADC_WIDTH] = sample_i;
    last_lane_c = (lane_q == LANE_W'(SPW - 1));

    // Word includes the sample being accepted this edge; unfilled lanes are already zero.
    word_c = '0;
    word_c[DATA_W-1:0] = acc_i ? lanes_ins : lanes_q;
    word_c[WORD_WIDTH-1-OR_BIT_FROM_MSB]   = or_q | (acc_i & or_i);
    word_c[WORD_WIDTH-1-TRIG_BIT_FROM_MSB] = acc_i ? trig_i : trig_q;

    lanes_d = lanes_q;
    lane_d  = lane_q;
    or_d    = or_q;
    trig_d  = trig_q;
    if (clr_i || flush_i || (acc_i && last_lane_c)) begin
      lanes_d = '0;
      lane_d  = '0;
      or_d    = 1'b0;
      trig_d  = 1'b0;
    end else if (acc_i) begin
      lanes_d = lanes_ins;
      lane_d  = lane_q + LANE_W'(1);
      or_d    = or_q | or_i;
      trig_d  = trig_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q <= '0;
      lane_q  <= '0;
      or_q    <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      lane_q  <= lane_d;
      or_q    <= or_d;
      trig_q  <= trig_d;
    end
  end

  assign lane_o = lane_q;

endmodule

// File: rtl/adc_capture_packer.sv
// ADC capture front end: trigger-armed start, decimation, sample counting, and
// registered FIFO writes of packed words with flush and sticky overflow.
module adc_capture_packer
  import adc_capture_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = 10,
  parameter int unsigned SPW        = 3,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DEC_WIDTH  = 16
) (
  input  logic                 adc_sampleclk,
  input  logic                 reset_i,
  input  logic [ADC_WIDTH-1:0] adc_datain,
  input  logic                 adc_or,
  input  logic                 adc_trig_status,
  input  logic                 capture_go_i,
  input  logic                 trig_mode_i,
  input  logic [DEC_WIDTH-1:0] decimate_i,
  input  logic [31:0]          max_samples_i,
  adc_capture_packer_if.master fifo,
  output logic                 capture_stop_o,
  output logic                 capture_busy_o,
  output logic                 overflow_o,
  output logic [31:0]          samples_o
);

  localparam int unsigned LANE_W = (SPW > 1) ? $clog2(SPW) : 1;

  if (!word_width_ok(WORD_WIDTH, SPW, ADC_WIDTH)) begin : g_bad_width
    $error("adc_capture_packer: WORD_WIDTH must be >= SPW*ADC_WIDTH+2 with SPW in 1..4");
  end

  cap_state_e            state_q, state_d;
  logic [31:0]           samples_q, samples_d, max_q, max_d;
  logic [DEC_WIDTH-1:0]  dec_q, dec_d, lim_q, lim_d;
  logic                  ovf_q, ovf_d, trig_prev_q;
  logic                  wr_en_q, wr_en_d, stop_q, stop_d, busy_q, busy_d;
  logic [WORD_WIDTH-1:0] din_q, din_d, word;
  logic [LANE_W-1:0]     lane;
  logic                  last_lane, run, acc, flush, clr, has_room, trig_rise;

  adc_lane_packer #(
    .ADC_WIDTH (ADC_WIDTH),
    .SPW       (SPW),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_lanes (
    .clk        (adc_sampleclk),
    .rst_n      (reset_i),
    .clr_i      (clr),
    .acc_i      (acc),
    .flush_i    (flush),
    .sample_i   (adc_datain),
    .or_i       (adc_or),
    .trig_i     (adc_trig_status),
    .lane_o     (lane),
    .last_lane_c(last_lane),
    .word_c     (word)
  );

  assign has_room  = (samples_q < max_q);
  assign trig_rise = adc_trig_status & ~trig_prev_q;

  always_comb begin
    state_d   = state_q;
    samples_d = samples_q;
    max_d     = max_q;
    ovf_d     = ovf_q;
    dec_d     = dec_q;
    lim_d     = lim_q;
    din_d     = din_q;
    wr_en_d   = 1'b0;
    run       = 1'b0;
    acc       = 1'b0;
    flush     = 1'b0;
    clr       = 1'b0;

    if (!capture_go_i) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          clr       = 1'b1;
          samples_d = '0;
          ovf_d     = 1'b0;
          dec_d     = '0;
          lim_d     = decimate_i;
          max_d     = max_samples_i;
          state_d   = trig_mode_i ? ST_ARMED : ST_CAPTURE;
        end
        ST_ARMED: begin
          // The trigger-edge sample is the first one captured.
          if (trig_rise) begin
            state_d = ST_CAPTURE;
            run     = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (has_room) begin
            run = 1'b1;
          end else begin
            flush   = (lane != '0);
            state_d = flush ? ST_FLUSH : ST_DONE;
          end
        end
        ST_FLUSH: state_d = ST_DONE;
        default:  ;
      endcase

      if (run) begin
        // New decimation ratio is only picked up at a wrap.
        dec_d = (dec_q == lim_q) ? '0 : dec_q + DEC_WIDTH'(1);
        if (dec_q == lim_q) lim_d = decimate_i;
        if ((dec_q == '0) && has_room) begin
          acc       = 1'b1;
          samples_d = samples_q + 32'd1;
        end
      end

      if ((acc && last_lane) || flush) begin
        if (fifo.fifo_full_i) begin
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wr_en_d = 1'b1;
          din_d   = word;
        end
      end
    end

    stop_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE) || (state_d == ST_FLUSH);
  end

  always_ff @(posedge adc_sampleclk or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      samples_q   <= '0;
      max_q       <= '0;
      ovf_q       <= 1'b0;
      dec_q       <= '0;
      lim_q       <= '0;
      trig_prev_q <= 1'b0;
      wr_en_q     <= 1'b0;
      din_q       <= '0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      samples_q   <= samples_d;
      max_q       <= max_d;
      ovf_q       <= ovf_d;
      dec_q       <= dec_d;
      lim_q       <= lim_d;
      trig_prev_q <= adc_trig_status;
      wr_en_q     <= wr_en_d;
      din_q       <= din_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
    end
  end

  assign fifo.fifo_wr_en_o = wr_en_q;
  assign fifo.fifo_din_o   = din_q;
  assign capture_stop_o    = stop_q;
  assign capture_busy_o    = busy_q;
  assign overflow_o        = ovf_q;
  assign samples_o         = samples_q;

endmodule

// File: tb/tb_adc_capture_packer.sv
// Randomized and directed bench for adc_capture_packer against a list-based capture model.
module tb_adc_capture_packer;

  localparam int unsigned AW   = 10;
  localparam int unsigned SPW  = 3;
  localparam int unsigned WW   = 32;
  localparam int unsigned DW   = 16;
  localparam int          NMAX = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] adc_d;
  logic          adc_or, adc_trig, go, mode;
  logic [DW-1:0] dec;
  logic [31:0]   max_s, samples;
  logic          stop, busy, ovf;

  always #5 clk = ~clk;

  adc_capture_packer_if #(.WORD_WIDTH(WW)) fifo_if ();

  adc_capture_packer #(
    .ADC_WIDTH(AW), .SPW(SPW), .WORD_WIDTH(WW), .DEC_WIDTH(DW)
  ) dut (
    .adc_sampleclk  (clk),
    .reset_i        (rst_n),
    .adc_datain     (adc_d),
    .adc_or         (adc_or),
    .adc_trig_status(adc_trig),
    .capture_go_i   (go),
    .trig_mode_i    (mode),
    .decimate_i     (dec),
    .max_samples_i  (max_s),
    .fifo           (fifo_if),
    .capture_stop_o (stop),
    .capture_busy_o (busy),
    .overflow_o     (ovf),
    .samples_o      (samples)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus per edge; edge 0 is the first edge that sees go high.
  logic [AW-1:0] d_a [NMAX];
  bit            or_a[NMAX], tr_a[NMAX], fu_a[NMAX];

  int            exp_e[$], obs_e[$];
  logic [WW-1:0] exp_w[$], obs_w[$];
  int            exp_samples, run_len;
  bit            exp_ovf;

  function automatic void emit(input int e, input logic [SPW*AW-1:0] lanes, input bit orr, input bit tl);
    logic [WW-1:0] w;
    if (fu_a[e]) begin
      exp_ovf = 1'b1;
    end else begin
      w = '0;
      w[SPW*AW-1:0] = lanes;
      w[WW-1] = orr;
      w[WW-2] = tl;
      exp_e.push_back(e);
      exp_w.push_back(w);
    end
  endfunction

  // Accepted samples sit at s, s+(d+1), ...; complete words leave on their last sample's
  // edge, a partial tail one edge after the last sample; full at that edge ends the run.
  function automatic void model(input bit m, input int d, input int mx);
    int s, a;
    logic [SPW*AW-1:0] lanes;
    bit orr, tl;
    exp_e.delete(); exp_w.delete();
    exp_ovf = 1'b0; exp_samples = 0;
    s = 1;
    if (m) begin
      s = -1;
      for (int t = 1; t < NMAX; t++) if (s < 0 && tr_a[t] && !tr_a[t-1]) s = t;
    end
    run_len = s + mx * (d + 1) + 4;
    lanes = '0; orr = 1'b0; tl = 1'b0;
    for (int k = 0; k < mx && !exp_ovf; k++) begin
      a = s + k * (d + 1);
      lanes[(k % SPW) * AW +: AW] = d_a[a];
      orr = orr | or_a[a];
      tl  = tr_a[a];
      exp_samples++;
      if (k % SPW == SPW - 1) begin
        emit(a, lanes, orr, tl);
        lanes = '0; orr = 1'b0;
      end
    end
    if (!exp_ovf && (mx % SPW) != 0) emit(s + (mx - 1) * (d + 1) + 1, lanes, orr, tl);
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    go = 1'b0; adc_trig = 1'b0; adc_or = 1'b0; fifo_if.fifo_full_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input string name, input bit m, input int d, input int mx,
                     input bit ramp, input int trig_at, input int full_from);
    for (int t = 0; t < NMAX; t++) begin
      d_a[t]  = ramp ? AW'(t) : AW'($urandom);
      or_a[t] = ramp ? 1'b0 : ($urandom_range(0, 7) == 0);
      tr_a[t] = (trig_at >= 0) ? (t >= trig_at) : 1'($urandom_range(0, 1));
      fu_a[t] = (full_from >= 0) ? (t >= full_from) : ($urandom_range(0, 15) == 0);
    end
    if (trig_at < 0) begin
      tr_a[8] = 1'b0;
      tr_a[9] = 1'b1;
    end
    model(m, d, mx);
    obs_e.delete(); obs_w.delete();
    for (int t = 0; t < run_len; t++) begin
      @(negedge clk);
      go = 1'b1; mode = m; dec = DW'(d); max_s = 32'(mx);
      adc_d = d_a[t]; adc_or = or_a[t]; adc_trig = tr_a[t]; fifo_if.fifo_full_i = fu_a[t];
      @(posedge clk); #1;
      if (fifo_if.fifo_wr_en_o) begin
        obs_e.push_back(t);
        obs_w.push_back(fifo_if.fifo_din_o);
      end
      if (t == 0) check({name, " start"}, 64'({busy, stop, ovf, samples}), 64'({1'b1, 1'b0, 1'b0, 32'd0}));
    end
    check({name, " nwr"}, 64'(obs_e.size()), 64'(exp_e.size()));
    for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++) begin
      check({name, " edge"}, 64'(obs_e[i]), 64'(exp_e[i]));
      check({name, " word"}, 64'(obs_w[i]), 64'(exp_w[i]));
    end
    check({name, " end"}, 64'({stop, busy, ovf, samples}), 64'({1'b1, 1'b0, exp_ovf, 32'(exp_samples)}));
    idle_cycle();
    check({name, " idle"}, 64'({busy, stop}), 64'(0));
  endtask

  logic [WW-1:0] w0;
  int            nwr;

  initial begin
    rst_n = 1'b0; go = 1'b0; mode = 1'b0; dec = '0; max_s = '0;
    adc_d = '0; adc_or = 1'b0; adc_trig = 1'b0; fifo_if.fifo_full_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 64'({fifo_if.fifo_wr_en_o, fifo_if.fifo_din_o, stop, busy, ovf, samples}), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    idle_cycle();

    run("t1", 1'b0, 0, 6, 1'b1, NMAX, -1);
    w0 = obs_w[0];
    check("t1 w0 const", 64'(w0), 64'(32'h0030_0801));
    w0 = obs_w[1];
    check("t1 w1 const", 64'(w0), 64'(32'h0060_1404));

    run("t2", 1'b0, 0, 4, 1'b1, NMAX, -1);
    w0 = obs_w[1];
    check("t2 flush const", 64'(w0), 64'(32'h0000_0004));

    run("t3", 1'b1, 0, 6, 1'b1, 5, -1);
    w0 = obs_w[0];
    check("t3 first lane", 64'(w0[AW-1:0]), 64'(5));

    run("t4", 1'b0, 2, 6, 1'b1, NMAX, -1);
    run("t5", 1'b0, 0, 6, 1'b0, -1, 4);
    run("t5b", 1'b0, 0, 3, 1'b0, -1, NMAX);

    // go dropped mid-word: partial word discarded, then restart clears the count.
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      go = 1'b1; mode = 1'b0; dec = '0; max_s = 32'd6; adc_d = AW'(t + 1);
      @(posedge clk); #1;
    end
    check("t6 pre-abort samples", 64'(samples), 64'(2));
    nwr = 0;
    @(negedge clk); go = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      if (fifo_if.fifo_wr_en_o) nwr++;
    end
    check("t6 abort nwr", 64'(nwr), 64'(0));
    check("t6 abort busy", 64'(busy), 64'(0));

    // Restart, run into the second word, then async reset between edges.
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      go = 1'b1; adc_d = AW'(t + 7);
      @(posedge clk); #1;
      if (t == 0) check("t6 restart samples", 64'(samples), 64'(0));
    end
    check("t6 pre-reset samples", 64'(samples), 64'(4));
    #2 rst_n = 1'b0;
    #1;
    check("t6 async reset", 64'({fifo_if.fifo_wr_en_o, fifo_if.fifo_din_o, stop, busy, ovf, samples}), 64'(0));
    @(negedge clk); go = 1'b0; rst_n = 1'b1;
    idle_cycle();

    for (int i = 0; i < 12; i++) begin
      run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          $urandom_range(0, 20), 1'b0, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
